bit_sync_filter_pulse: RTL and testbench

- Parametrised multi-channel successor to the plain N-stage bit synchroniser.
- Each channel has an NUM_STAGES-flop synchroniser, a per-channel stability (glitch) filter, and a one-cycle edge-pulse generator with selectable edge mode.
- Sits at the destination-clock boundary for asynchronous level inputs (status lines, buttons, handshake flags).
- Feeds control logic that needs a clean level and/or a single-cycle event.

---
 rtl/bit_sync_filter_pulse.sv | 81 ++++++++
 tb/tb_bit_sync_filter_pulse.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_sync_filter_pulse.sv
// Multi-channel level synchroniser with per-channel glitch filter
// and registered edge-pulse generator.
module bit_sync_filter_pulse #(
  parameter int BUS_WIDTH     = 4,
  parameter int NUM_STAGES    = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int EDGE_MODE     = 2
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 EN,
  input  logic [BUS_WIDTH-1:0] ASYNC,
  output logic [BUS_WIDTH-1:0] SYNC,
  output logic [BUS_WIDTH-1:0] STABLE,
  output logic [BUS_WIDTH-1:0] PULSE
);

  localparam int CW =
    (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic CNT_ONE_MSB = 1'b0;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic RISE_EN = (EDGE_MODE != 1);
  localparam logic FALL_EN = (EDGE_MODE != 0);

  logic [NUM_STAGES-1:0][BUS_WIDTH-1:0] chain;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[NUM_STAGES-2:0], ASYNC};
    end
  end

  assign SYNC = chain[NUM_STAGES-1];

  for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          stable_q;
    logic          pulse_q;
    logic          differ;
    logic          expire;
    logic          hit;

    always_comb begin
      differ = SYNC[i] ^ stable_q;
      expire = differ && (cnt == CNT_LAST);
      hit    = 1'b0;
      unique case (1'b1)
        SYNC[i]:  hit = RISE_EN;
        !SYNC[i]: hit = FALL_EN;
        default:  hit = 1'b0;
      endcase
    end

    // Pulse is registered with the STABLE update so both
    // are visible in the same cycle.
    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
        cnt      <= '0;
        stable_q <= 1'b0;
        pulse_q  <= 1'b0;
      end else if (!EN || !differ) begin
        cnt      <= '0;
        pulse_q  <= 1'b0;
      end else if (expire) begin
        cnt      <= '0;
        stable_q <= SYNC[i];
        pulse_q  <= hit;
      end else begin
        cnt      <= cnt + CNT_ONE;
        pulse_q  <= CNT_ONE_MSB;
      end
    end

    assign STABLE[i] = stable_q;
    assign PULSE[i]  = pulse_q;
  end

endmodule

// File: tb/tb_bit_sync_filter_pulse.sv
// Scoreboard bench: directed hand-computed vectors on the default
// configuration plus a randomised model sweep over six configurations.
module tb_bit_sync_filter_pulse;

  localparam int NC = 6;
  localparam int MAIN = 1;

  logic       CLK;
  logic       RST_n;
  logic       EN;
  logic [3:0] ASYNC;

  logic [3:0] sy_w [NC];
  logic [3:0] st_w [NC];
  logic [3:0] pu_w [NC];
  logic [3:0] sy_r, st_r, pu_r;
  logic [3:0] sy_f, st_f, pu_f;

  function automatic int stg(int g);
    return (g < 3) ? 2 : 4;
  endfunction

  function automatic int flt(int g);
    return 2 * (g % 3) + 1;
  endfunction

  for (genvar g = 0; g < NC; g++) begin : g_dut
    bit_sync_filter_pulse #(
      .BUS_WIDTH(4),
      .NUM_STAGES(stg(g)),
      .FILTER_CYCLES(flt(g)),
      .EDGE_MODE(2)
    ) u_dut (
      .CLK(CLK), .RST_n(RST_n), .EN(EN), .ASYNC(ASYNC),
      .SYNC(sy_w[g]), .STABLE(st_w[g]), .PULSE(pu_w[g])
    );
  end

  bit_sync_filter_pulse #(
    .BUS_WIDTH(4), .NUM_STAGES(2), .FILTER_CYCLES(3), .EDGE_MODE(0)
  ) u_rise (
    .CLK(CLK), .RST_n(RST_n), .EN(EN), .ASYNC(ASYNC),
    .SYNC(sy_r), .STABLE(st_r), .PULSE(pu_r)
  );

  bit_sync_filter_pulse #(
    .BUS_WIDTH(4), .NUM_STAGES(2), .FILTER_CYCLES(3), .EDGE_MODE(1)
  ) u_fall (
    .CLK(CLK), .RST_n(RST_n), .EN(EN), .ASYNC(ASYNC),
    .SYNC(sy_f), .STABLE(st_f), .PULSE(pu_f)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic                rnd;
    logic [3:0]          sy;
    logic [3:0]          st;
    logic [3:0]          pu;
    logic [NC-1:0][3:0]  rsy;
    logic [NC-1:0][3:0]  rst;
    logic [NC-1:0][3:0]  rpu;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock edge while stimulus runs.
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (!mon_e.rnd) begin
        chk("sync", sy_w[MAIN], mon_e.sy);
        chk("stable", st_w[MAIN], mon_e.st);
        chk("pulse", pu_w[MAIN], mon_e.pu);
        chk("stable_rise", st_r, mon_e.st);
        chk("pulse_rise", pu_r, mon_e.pu & mon_e.st);
        chk("stable_fall", st_f, mon_e.st);
        chk("pulse_fall", pu_f, mon_e.pu & ~mon_e.st);
      end else begin
        for (int g = 0; g < NC; g++) begin
          chk($sformatf("rnd_sync%0d", g), sy_w[g], mon_e.rsy[g]);
          chk($sformatf("rnd_stable%0d", g), st_w[g], mon_e.rst[g]);
          chk($sformatf("rnd_pulse%0d", g), pu_w[g], mon_e.rpu[g]);
        end
        chk("rnd_pulse_rise", pu_r, mon_e.rpu[MAIN] & mon_e.rst[MAIN]);
        chk("rnd_pulse_fall", pu_f, mon_e.rpu[MAIN] & ~mon_e.rst[MAIN]);
      end
    end
  end

  task automatic row(input logic [3:0] a, input logic en,
                     input logic [3:0] sy, input logic [3:0] st,
                     input logic [3:0] pu);
    exp_t e;
    @(negedge CLK);
    ASYNC = a;
    EN    = en;
    e     = '0;
    e.sy  = sy;
    e.st  = st;
    e.pu  = pu;
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(input string nm);
    for (int g = 0; g < NC; g++) begin
      chk({nm, "_sync"}, sy_w[g], 4'h0);
      chk({nm, "_stable"}, st_w[g], 4'h0);
      chk({nm, "_pulse"}, pu_w[g], 4'h0);
    end
    chk({nm, "_pulse_rise"}, pu_r, 4'h0);
    chk({nm, "_pulse_fall"}, pu_f, 4'h0);
  endtask

  // Assert reset between edges, check outputs clear with no edge,
  // then release between a posedge and the next negedge.
  task automatic mid_reset(input string nm, input logic [3:0] a);
    @(negedge CLK);
    #2 RST_n = 1'b0;
    ASYNC = a;
    #1 chk_zero(nm);
    repeat (2) @(posedge CLK);
    #3 RST_n = 1'b1;
  endtask

  // Reference model for the random sweep.
  logic [3:0] m_ch [NC][8];
  logic [3:0] m_st [NC];
  logic [3:0] m_pu [NC];
  int         m_cnt [NC][4];

  task automatic model_reset();
    for (int g = 0; g < NC; g++) begin
      for (int k = 0; k < 8; k++) m_ch[g][k] = 4'h0;
      m_st[g] = 4'h0;
      m_pu[g] = 4'h0;
      for (int i = 0; i < 4; i++) m_cnt[g][i] = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] a, input logic en);
    logic [3:0] so;
    for (int g = 0; g < NC; g++) begin
      so = m_ch[g][stg(g)-1];
      for (int k = 7; k > 0; k--) m_ch[g][k] = m_ch[g][k-1];
      m_ch[g][0] = a;
      m_pu[g] = 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (!en || so[i] == m_st[g][i]) begin
          m_cnt[g][i] = 0;
        end else if (m_cnt[g][i] >= flt(g) - 1) begin
          m_st[g][i] = so[i];
          m_pu[g][i] = 1'b1;
          m_cnt[g][i] = 0;
        end else begin
          m_cnt[g][i]++;
        end
      end
    end
  endtask

  initial begin
    exp_t e;
    logic [3:0] ra;
    logic       ren;
    int         hold;
    int         cyc;
    RST_n = 1'b0;
    EN    = 1'b1;
    ASYNC = 4'h0;
    #3 chk_zero("reset");
    @(posedge CLK);
    #3 RST_n = 1'b1;

    // Latency: capture edge 0, SYNC after edge 1, STABLE after edge 4.
    row(4'h1, 1, 4'h0, 4'h0, 4'h0);
    row(4'h1, 1, 4'h1, 4'h0, 4'h0);
    row(4'h1, 1, 4'h1, 4'h0, 4'h0);
    row(4'h1, 1, 4'h1, 4'h0, 4'h0);
    row(4'h1, 1, 4'h1, 4'h1, 4'h1);
    row(4'h1, 1, 4'h1, 4'h1, 4'h0);
    // Two-cycle glitch on channel 2 is rejected.
    row(4'h5, 1, 4'h1, 4'h1, 4'h0);
    row(4'h5, 1, 4'h5, 4'h1, 4'h0);
    row(4'h1, 1, 4'h5, 4'h1, 4'h0);
    row(4'h1, 1, 4'h1, 4'h1, 4'h0);
    row(4'h1, 1, 4'h1, 4'h1, 4'h0);
    row(4'h1, 1, 4'h1, 4'h1, 4'h0);
    // Three-cycle excursion on channel 3 is just accepted.
    row(4'h9, 1, 4'h1, 4'h1, 4'h0);
    row(4'h9, 1, 4'h9, 4'h1, 4'h0);
    row(4'h9, 1, 4'h9, 4'h1, 4'h0);
    row(4'h1, 1, 4'h9, 4'h1, 4'h0);
    row(4'h1, 1, 4'h1, 4'h9, 4'h8);
    row(4'h1, 1, 4'h1, 4'h9, 4'h0);
    row(4'h1, 1, 4'h1, 4'h9, 4'h0);
    row(4'h1, 1, 4'h1, 4'h1, 4'h8);
    row(4'h1, 1, 4'h1, 4'h1, 4'h0);
    // Fall on channel 0.
    row(4'h0, 1, 4'h1, 4'h1, 4'h0);
    row(4'h0, 1, 4'h0, 4'h1, 4'h0);
    row(4'h0, 1, 4'h0, 4'h1, 4'h0);
    row(4'h0, 1, 4'h0, 4'h1, 4'h0);
    row(4'h0, 1, 4'h0, 4'h0, 4'h1);
    row(4'h0, 1, 4'h0, 4'h0, 4'h0);
    // Enable gating: SYNC tracks, STABLE frozen.
    row(4'hF, 0, 4'h0, 4'h0, 4'h0);
    row(4'hF, 0, 4'hF, 4'h0, 4'h0);
    row(4'hF, 0, 4'hF, 4'h0, 4'h0);
    row(4'hF, 0, 4'hF, 4'h0, 4'h0);
    row(4'hF, 0, 4'hF, 4'h0, 4'h0);
    row(4'hF, 0, 4'hF, 4'h0, 4'h0);
    row(4'hF, 1, 4'hF, 4'h0, 4'h0);
    row(4'hF, 1, 4'hF, 4'h0, 4'h0);
    row(4'hF, 1, 4'hF, 4'hF, 4'hF);
    row(4'hF, 1, 4'hF, 4'hF, 4'h0);
    // EN drop mid-count restarts the filter.
    row(4'h0, 1, 4'hF, 4'hF, 4'h0);
    row(4'h0, 1, 4'h0, 4'hF, 4'h0);
    row(4'h0, 1, 4'h0, 4'hF, 4'h0);
    row(4'h0, 0, 4'h0, 4'hF, 4'h0);
    row(4'h0, 1, 4'h0, 4'hF, 4'h0);
    row(4'h0, 1, 4'h0, 4'hF, 4'h0);
    row(4'h0, 1, 4'h0, 4'h0, 4'hF);
    row(4'h0, 1, 4'h0, 4'h0, 4'h0);
    // Reset one cycle before STABLE would update.
    row(4'h1, 1, 4'h0, 4'h0, 4'h0);
    row(4'h1, 1, 4'h1, 4'h0, 4'h0);
    row(4'h1, 1, 4'h1, 4'h0, 4'h0);
    row(4'h1, 1, 4'h1, 4'h0, 4'h0);
    mid_reset("midrst1", 4'h1);
    row(4'h1, 1, 4'h0, 4'h0, 4'h0);
    row(4'h1, 1, 4'h1, 4'h0, 4'h0);
    row(4'h1, 1, 4'h1, 4'h0, 4'h0);
    row(4'h1, 1, 4'h1, 4'h0, 4'h0);
    row(4'h1, 1, 4'h1, 4'h1, 4'h1);
    row(4'h1, 1, 4'h1, 4'h1, 4'h0);
    mid_reset("midrst2", 4'h0);
    for (int k = 0; k < 4; k++) row(4'h0, 1, 4'h0, 4'h0, 4'h0);
    // Edge modes: 8-cycle high then 8-cycle low on channel 0.
    row(4'h1, 1, 4'h0, 4'h0, 4'h0);
    row(4'h1, 1, 4'h1, 4'h0, 4'h0);
    row(4'h1, 1, 4'h1, 4'h0, 4'h0);
    row(4'h1, 1, 4'h1, 4'h0, 4'h0);
    row(4'h1, 1, 4'h1, 4'h1, 4'h1);
    for (int k = 0; k < 3; k++) row(4'h1, 1, 4'h1, 4'h1, 4'h0);
    row(4'h0, 1, 4'h1, 4'h1, 4'h0);
    row(4'h0, 1, 4'h0, 4'h1, 4'h0);
    row(4'h0, 1, 4'h0, 4'h1, 4'h0);
    row(4'h0, 1, 4'h0, 4'h1, 4'h0);
    row(4'h0, 1, 4'h0, 4'h0, 4'h1);
    for (int k = 0; k < 3; k++) row(4'h0, 1, 4'h0, 4'h0, 4'h0);

    // Random sweep across all configurations.
    mid_reset("rndrst", 4'h0);
    model_reset();
    cyc = 0;
    while (cyc < 500) begin
      ra   = 4'($urandom);
      ren  = ($urandom_range(0, 9) != 0);
      hold = $urandom_range(1, 10);
      for (int k = 0; k < hold; k++) begin
        @(negedge CLK);
        ASYNC = ra;
        EN    = ren;
        model_step(ra, ren);
        e     = '0;
        e.rnd = 1'b1;
        for (int g = 0; g < NC; g++) begin
          e.rsy[g] = m_ch[g][stg(g)-1];
          e.rst[g] = m_st[g];
          e.rpu[g] = m_pu[g];
        end
        exp_q.push_back(e);
        cyc++;
      end
    end

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge CLK);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
